fpu_issue_unit: RTL and testbench

- Initiator that feeds one iterative FPU arithmetic unit (divider, multiplier or adder) from a packed IEEE-754 request stream.
- Decomposes each operand pair into sign/exponent/fraction, computes operand metadata and special-value flags, and issues a one-cycle data_valid strobe.
- Waits for the unit's data_valid response, captures the result and exception flags, and returns them to the host over a valid/ready channel.
- Sits between the top-level FPU command path and each arithmetic unit; one instance per unit.

---
 rtl/fpu_issue_unit_if.sv | 57 +++++
 rtl/fpu_issue_unit.sv | 180 ++++++++++++++++++
 tb/tb_fpu_issue_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_unit_if.sv
// Bundle of the host request/response channels and the arithmetic-unit issue/return channel
// for one fpu_issue_unit. The master modport is the issue unit's view.
interface fpu_issue_unit_if;
  // Host request
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_x_i;
  logic [31:0] req_y_i;
  // Issue to the arithmetic unit
  logic        unit_data_valid_o;
  logic        unit_x_sign_o;
  logic        unit_y_sign_o;
  logic [7:0]  unit_x_exp_o;
  logic [7:0]  unit_y_exp_o;
  logic [22:0] unit_x_frac_o;
  logic [22:0] unit_y_frac_o;
  logic        unit_x_greater_o;
  logic [7:0]  unit_exp_shift_o;
  logic        unit_x_infinity_o;
  logic        unit_y_infinity_o;
  logic        unit_x_nan_o;
  logic        unit_y_nan_o;
  // Return from the arithmetic unit
  logic        unit_data_valid_i;
  logic [31:0] unit_z_i;
  logic        unit_invalid_i;
  logic        unit_overflow_i;
  // Host response
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_z_o;
  logic        rsp_invalid_o;
  logic        rsp_overflow_o;
  logic        rsp_timeout_o;

  modport master (
    input  req_valid_i, req_x_i, req_y_i,
    output req_ready_o,
    output unit_data_valid_o, unit_x_sign_o, unit_y_sign_o, unit_x_exp_o, unit_y_exp_o,
    output unit_x_frac_o, unit_y_frac_o, unit_x_greater_o, unit_exp_shift_o,
    output unit_x_infinity_o, unit_y_infinity_o, unit_x_nan_o, unit_y_nan_o,
    input  unit_data_valid_i, unit_z_i, unit_invalid_i, unit_overflow_i,
    output rsp_valid_o, rsp_z_o, rsp_invalid_o, rsp_overflow_o, rsp_timeout_o,
    input  rsp_ready_i
  );

  modport slave (
    output req_valid_i, req_x_i, req_y_i,
    input  req_ready_o,
    input  unit_data_valid_o, unit_x_sign_o, unit_y_sign_o, unit_x_exp_o, unit_y_exp_o,
    input  unit_x_frac_o, unit_y_frac_o, unit_x_greater_o, unit_exp_shift_o,
    input  unit_x_infinity_o, unit_y_infinity_o, unit_x_nan_o, unit_y_nan_o,
    output unit_data_valid_i, unit_z_i, unit_invalid_i, unit_overflow_i,
    input  rsp_valid_o, rsp_z_o, rsp_invalid_o, rsp_overflow_o, rsp_timeout_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/fpu_issue_unit.sv
// Decomposes IEEE-754 single operand pairs, issues them to one iterative FPU unit and returns
// its result to the host. Define FPU_ISSUE_TIMEOUT_EN to bound the wait for the unit.
module fpu_issue_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk_i,
  input logic              rst_i,
  fpu_issue_unit_if.master bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic        req_ready_q;
  logic        accept;
  logic        unit_done;
  logic        tmo_expire;
  logic        unit_issue;
  logic        rsp_valid;

  logic        x_sign_q, y_sign_q;
  logic [7:0]  x_exp_q, y_exp_q;
  logic [22:0] x_frac_q, y_frac_q;
  logic        x_greater_q;
  logic [7:0]  exp_shift_q;
  logic        x_inf_q, y_inf_q, x_nan_q, y_nan_q;

  logic [31:0] rsp_z_q;
  logic        rsp_invalid_q;
  logic        rsp_overflow_q;

  logic [7:0]  x_exp, y_exp;
  logic [22:0] x_frac, y_frac;

  assign x_exp  = bus.req_x_i[30:23];
  assign y_exp  = bus.req_y_i[30:23];
  assign x_frac = bus.req_x_i[22:0];
  assign y_frac = bus.req_y_i[22:0];

  // req_ready_q is only ever high in IDLE, so it alone qualifies an accept.
  assign accept    = bus.req_valid_i & req_ready_q;
  assign unit_done = (state_q == StWait) & bus.unit_data_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == StIdle);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (bus.unit_data_valid_i || tmo_expire) state_d = StResp;
      StResp:  if (bus.rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unit_issue = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      StIssue: unit_issue = 1'b1;
      StResp:  rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  // Operand metadata is held from one accept to the next.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_sign_q    <= 1'b0;
      y_sign_q    <= 1'b0;
      x_exp_q     <= '0;
      y_exp_q     <= '0;
      x_frac_q    <= '0;
      y_frac_q    <= '0;
      x_greater_q <= 1'b0;
      exp_shift_q <= '0;
      x_inf_q     <= 1'b0;
      y_inf_q     <= 1'b0;
      x_nan_q     <= 1'b0;
      y_nan_q     <= 1'b0;
    end else if (accept) begin
      x_sign_q    <= bus.req_x_i[31];
      y_sign_q    <= bus.req_y_i[31];
      x_exp_q     <= x_exp;
      y_exp_q     <= y_exp;
      x_frac_q    <= x_frac;
      y_frac_q    <= y_frac;
      x_greater_q <= (bus.req_x_i[30:0] >= bus.req_y_i[30:0]);
      exp_shift_q <= (x_exp >= y_exp) ? (x_exp - y_exp) : (y_exp - x_exp);
      x_inf_q     <= (x_exp == 8'hFF) && (x_frac == '0);
      y_inf_q     <= (y_exp == 8'hFF) && (y_frac == '0);
      x_nan_q     <= (x_exp == 8'hFF) && (x_frac != '0);
      y_nan_q     <= (y_exp == 8'hFF) && (y_frac != '0);
    end
  end

  // A unit response in the expiry cycle takes priority over the timeout result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_z_q        <= '0;
      rsp_invalid_q  <= 1'b0;
      rsp_overflow_q <= 1'b0;
    end else if (unit_done) begin
      rsp_z_q        <= bus.unit_z_i;
      rsp_invalid_q  <= bus.unit_invalid_i;
      rsp_overflow_q <= bus.unit_overflow_i;
    end else if (tmo_expire) begin
      rsp_z_q        <= 32'h7FC0_0000;
      rsp_invalid_q  <= 1'b1;
      rsp_overflow_q <= 1'b0;
    end
  end

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_q;
  logic       rsp_timeout_q;

  // Counter is 0 in the first WAIT cycle, so expiry lands on the TIMEOUT_CYCLES-th one.
  assign tmo_expire = (state_q == StWait) && (tmo_cnt_q == TimeoutLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        tmo_cnt_q <= '0;
      end else if (state_q == StWait) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
      if (unit_done) begin
        rsp_timeout_q <= 1'b0;
      end else if (tmo_expire) begin
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.rsp_timeout_o = rsp_timeout_q;
`else
  assign tmo_expire        = 1'b0;
  assign bus.rsp_timeout_o = 1'b0;
`endif

  assign bus.req_ready_o       = req_ready_q;
  assign bus.unit_data_valid_o = unit_issue;
  assign bus.unit_x_sign_o     = x_sign_q;
  assign bus.unit_y_sign_o     = y_sign_q;
  assign bus.unit_x_exp_o      = x_exp_q;
  assign bus.unit_y_exp_o      = y_exp_q;
  assign bus.unit_x_frac_o     = x_frac_q;
  assign bus.unit_y_frac_o     = y_frac_q;
  assign bus.unit_x_greater_o  = x_greater_q;
  assign bus.unit_exp_shift_o  = exp_shift_q;
  assign bus.unit_x_infinity_o = x_inf_q;
  assign bus.unit_y_infinity_o = y_inf_q;
  assign bus.unit_x_nan_o      = x_nan_q;
  assign bus.unit_y_nan_o      = y_nan_q;
  assign bus.rsp_valid_o       = rsp_valid;
  assign bus.rsp_z_o           = rsp_z_q;
  assign bus.rsp_invalid_o     = rsp_invalid_q;
  assign bus.rsp_overflow_o    = rsp_overflow_q;

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Self-checking bench for fpu_issue_unit: table of operand pairs with hand-computed metadata,
// plus directed sequences for backpressure, reset in WAIT and the WAIT timeout.
module tb_fpu_issue_unit;

  localparam int unsigned TbTimeout = 8;

  logic clk;
  logic rst;

  fpu_issue_unit_if bus ();

  fpu_issue_unit #(
    .TIMEOUT_CYCLES(TbTimeout)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        xs;
    logic        ys;
    logic [7:0]  xe;
    logic [7:0]  ye;
    logic [22:0] xf;
    logic [22:0] yf;
    logic        xg;
    logic [7:0]  sh;
    logic        xi;
    logic        yi;
    logic        xn;
    logic        yn;
    logic [31:0] z;
    logic        inv;
    logic        ovf;
    int unsigned dly;
  } vec_t;

  localparam int NVec = 8;
  vec_t vecs[NVec];

  int n_cmp = 0;
  int n_err = 0;

  logic [114:0] all_outs;
  assign all_outs = {bus.req_ready_o, bus.unit_data_valid_o, bus.unit_x_sign_o,
                     bus.unit_y_sign_o, bus.unit_x_exp_o, bus.unit_y_exp_o, bus.unit_x_frac_o,
                     bus.unit_y_frac_o, bus.unit_x_greater_o, bus.unit_exp_shift_o,
                     bus.unit_x_infinity_o, bus.unit_y_infinity_o, bus.unit_x_nan_o,
                     bus.unit_y_nan_o, bus.rsp_valid_o, bus.rsp_z_o, bus.rsp_invalid_o,
                     bus.rsp_overflow_o, bus.rsp_timeout_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // With the timeout built, keep table responses clear of the expiry cycle.
  function automatic int unsigned eff_dly(input int unsigned d);
`ifdef FPU_ISSUE_TIMEOUT_EN
    return (d > TbTimeout - 2) ? TbTimeout - 2 : d;
`else
    return d;
`endif
  endfunction

  task automatic do_accept(input logic [31:0] x, input logic [31:0] y);
    int unsigned n = 0;
    while (!bus.req_ready_o && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_accept", 128'(bus.req_ready_o), 128'(1'b1));
    bus.req_valid_i = 1'b1;
    bus.req_x_i     = x;
    bus.req_y_i     = y;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic check_meta(input vec_t v, input string tag);
    chk({tag, "_x_sign"},  128'(bus.unit_x_sign_o),     128'(v.xs));
    chk({tag, "_y_sign"},  128'(bus.unit_y_sign_o),     128'(v.ys));
    chk({tag, "_x_exp"},   128'(bus.unit_x_exp_o),      128'(v.xe));
    chk({tag, "_y_exp"},   128'(bus.unit_y_exp_o),      128'(v.ye));
    chk({tag, "_x_frac"},  128'(bus.unit_x_frac_o),     128'(v.xf));
    chk({tag, "_y_frac"},  128'(bus.unit_y_frac_o),     128'(v.yf));
    chk({tag, "_x_gt"},    128'(bus.unit_x_greater_o),  128'(v.xg));
    chk({tag, "_shift"},   128'(bus.unit_exp_shift_o),  128'(v.sh));
    chk({tag, "_x_inf"},   128'(bus.unit_x_infinity_o), 128'(v.xi));
    chk({tag, "_y_inf"},   128'(bus.unit_y_infinity_o), 128'(v.yi));
    chk({tag, "_x_nan"},   128'(bus.unit_x_nan_o),      128'(v.xn));
    chk({tag, "_y_nan"},   128'(bus.unit_y_nan_o),      128'(v.yn));
  endtask

  // Entered in the ISSUE cycle; leaves in the first RESP cycle.
  task automatic finish_txn(input vec_t v);
    chk("issue_strobe", 128'(bus.unit_data_valid_o), 128'(1'b1));
    chk("ready_busy",   128'(bus.req_ready_o),       128'(1'b0));
    check_meta(v, "issue");
    tick();
    chk("strobe_one_cycle", 128'(bus.unit_data_valid_o), 128'(1'b0));
    chk("no_rsp_in_wait",   128'(bus.rsp_valid_o),       128'(1'b0));
    repeat (eff_dly(v.dly)) tick();
    bus.unit_data_valid_i = 1'b1;
    bus.unit_z_i          = v.z;
    bus.unit_invalid_i    = v.inv;
    bus.unit_overflow_i   = v.ovf;
    tick();
    bus.unit_data_valid_i = 1'b0;
    bus.unit_z_i          = '0;
    bus.unit_invalid_i    = 1'b0;
    bus.unit_overflow_i   = 1'b0;
    chk("rsp_valid",    128'(bus.rsp_valid_o),    128'(1'b1));
    chk("rsp_z",        128'(bus.rsp_z_o),        128'(v.z));
    chk("rsp_invalid",  128'(bus.rsp_invalid_o),  128'(v.inv));
    chk("rsp_overflow", 128'(bus.rsp_overflow_o), 128'(v.ovf));
    chk("rsp_timeout",  128'(bus.rsp_timeout_o),  128'(1'b0));
    chk("ready_in_rsp", 128'(bus.req_ready_o),    128'(1'b0));
    check_meta(v, "hold");
  endtask

  task automatic rsp_accept();
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("rsp_valid_drop", 128'(bus.rsp_valid_o), 128'(1'b0));
    chk("ready_return",   128'(bus.req_ready_o), 128'(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           x             y             xs    ys    xe     ye     xf          yf
    //           xg    sh     xi    yi    xn    yn    z             inv   ovf   dly
    vecs[0] = '{32'h40C00000, 32'h40000000, 1'b0, 1'b0, 8'h81, 8'h80, 23'h400000, 23'h000000,
                1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0, 9};
    vecs[1] = '{32'h7FC00000, 32'hFF800000, 1'b0, 1'b1, 8'hFF, 8'hFF, 23'h400000, 23'h000000,
                1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
    vecs[2] = '{32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 8'h7F, 8'h7F, 23'h000000, 23'h000000,
                1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 0};
    vecs[3] = '{32'hC0000000, 32'h41200000, 1'b1, 1'b0, 8'h80, 8'h82, 23'h000000, 23'h200000,
                1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 32'hBE4CCCCD, 1'b0, 1'b0, 3};
    vecs[4] = '{32'h00000001, 32'h80000000, 1'b0, 1'b1, 8'h00, 8'h00, 23'h000001, 23'h000000,
                1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[5] = '{32'h7F7FFFFF, 32'h00800000, 1'b0, 1'b0, 8'hFE, 8'h01, 23'h7FFFFF, 23'h000000,
                1'b1, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b0, 1'b1, 4};
    vecs[6] = '{32'h7F800000, 32'hFFC00001, 1'b0, 1'b1, 8'hFF, 8'hFF, 23'h000000, 23'h400001,
                1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7FC00000, 1'b1, 1'b0, 5};
    vecs[7] = '{32'h00800000, 32'h7F000000, 1'b0, 1'b0, 8'h01, 8'hFE, 23'h000000, 23'h000000,
                1'b0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 0};

    rst                   = 1'b1;
    bus.req_valid_i       = 1'b0;
    bus.req_x_i           = '0;
    bus.req_y_i           = '0;
    bus.unit_data_valid_i = 1'b0;
    bus.unit_z_i          = '0;
    bus.unit_invalid_i    = 1'b0;
    bus.unit_overflow_i   = 1'b0;
    bus.rsp_ready_i       = 1'b0;

    // Reset state and registered ready rising one cycle after release
    repeat (2) tick();
    chk("reset_outputs_zero", 128'(all_outs), 128'(0));
    rst = 1'b0;
    chk("ready_low_after_release", 128'(bus.req_ready_o), 128'(1'b0));
    tick();
    chk("ready_high_next_cycle", 128'(bus.req_ready_o), 128'(1'b1));

    for (int i = 0; i < NVec; i++) begin
      do_accept(vecs[i].x, vecs[i].y);
      finish_txn(vecs[i]);
      rsp_accept();
    end

    // Spurious unit strobe in IDLE leaves the response registers alone
    bus.unit_data_valid_i = 1'b1;
    bus.unit_z_i          = 32'h11111111;
    bus.unit_invalid_i    = 1'b1;
    tick();
    bus.unit_data_valid_i = 1'b0;
    bus.unit_invalid_i    = 1'b0;
    chk("idle_spurious_valid", 128'(bus.rsp_valid_o), 128'(1'b0));
    chk("idle_spurious_z",     128'(bus.rsp_z_o),     128'(vecs[7].z));
    chk("idle_spurious_inv",   128'(bus.rsp_invalid_o), 128'(1'b0));

    // Backpressure, spurious strobe and a request presented during RESP
    do_accept(vecs[5].x, vecs[5].y);
    finish_txn(vecs[5]);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.unit_data_valid_i = 1'b1;
        bus.unit_z_i          = 32'hDEADBEEF;
        bus.unit_invalid_i    = 1'b1;
        bus.unit_overflow_i   = 1'b0;
      end
      if (c == 3) begin
        bus.unit_data_valid_i = 1'b0;
        bus.unit_invalid_i    = 1'b0;
        bus.req_valid_i       = 1'b1;
        bus.req_x_i           = vecs[1].x;
        bus.req_y_i           = vecs[1].y;
      end
      tick();
      chk("bp_rsp_valid", 128'(bus.rsp_valid_o),    128'(1'b1));
      chk("bp_rsp_z",     128'(bus.rsp_z_o),        128'(vecs[5].z));
      chk("bp_rsp_inv",   128'(bus.rsp_invalid_o),  128'(vecs[5].inv));
      chk("bp_rsp_ovf",   128'(bus.rsp_overflow_o), 128'(vecs[5].ovf));
      chk("bp_ready_low", 128'(bus.req_ready_o),    128'(1'b0));
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("b2b_rsp_drop",  128'(bus.rsp_valid_o),       128'(1'b0));
    chk("b2b_ready",     128'(bus.req_ready_o),       128'(1'b1));
    chk("b2b_no_strobe", 128'(bus.unit_data_valid_o), 128'(1'b0));
    check_meta(vecs[5], "b2b_stable");
    tick();
    bus.req_valid_i = 1'b0;
    finish_txn(vecs[1]);
    rsp_accept();

    // Asynchronous reset in the middle of a WAIT cycle
    do_accept(vecs[3].x, vecs[3].y);
    tick();
    #2 rst = 1'b1;
    #1 chk("async_reset_zero", 128'(all_outs), 128'(0));
    tick();
    rst = 1'b0;
    chk("post_reset_zero", 128'(all_outs), 128'(0));
    bus.unit_data_valid_i = 1'b1;
    bus.unit_z_i          = 32'h12345678;
    bus.unit_invalid_i    = 1'b1;
    bus.unit_overflow_i   = 1'b1;
    tick();
    bus.unit_data_valid_i = 1'b0;
    bus.unit_z_i          = '0;
    bus.unit_invalid_i    = 1'b0;
    bus.unit_overflow_i   = 1'b0;
    chk("late_strobe_valid", 128'(bus.rsp_valid_o), 128'(1'b0));
    chk("late_strobe_z",     128'(bus.rsp_z_o),     128'(0));
    chk("late_strobe_ready", 128'(bus.req_ready_o), 128'(1'b1));
    do_accept(vecs[0].x, vecs[0].y);
    finish_txn(vecs[0]);
    rsp_accept();

    // No unit response at all
    do_accept(vecs[2].x, vecs[2].y);
`ifdef FPU_ISSUE_TIMEOUT_EN
    repeat (TbTimeout) tick();
    chk("tmo_not_yet", 128'(bus.rsp_valid_o), 128'(1'b0));
    tick();
    chk("tmo_rsp_valid", 128'(bus.rsp_valid_o),    128'(1'b1));
    chk("tmo_rsp_z",     128'(bus.rsp_z_o),        128'(32'h7FC00000));
    chk("tmo_rsp_inv",   128'(bus.rsp_invalid_o),  128'(1'b1));
    chk("tmo_rsp_ovf",   128'(bus.rsp_overflow_o), 128'(1'b0));
    chk("tmo_flag",      128'(bus.rsp_timeout_o),  128'(1'b1));
    rsp_accept();
    // Unit response in the expiry cycle wins
    do_accept(vecs[2].x, vecs[2].y);
    repeat (TbTimeout) tick();
    bus.unit_data_valid_i = 1'b1;
    bus.unit_z_i          = 32'h3F800000;
    bus.unit_overflow_i   = 1'b1;
    tick();
    bus.unit_data_valid_i = 1'b0;
    bus.unit_overflow_i   = 1'b0;
    chk("race_rsp_valid", 128'(bus.rsp_valid_o),    128'(1'b1));
    chk("race_rsp_z",     128'(bus.rsp_z_o),        128'(32'h3F800000));
    chk("race_rsp_ovf",   128'(bus.rsp_overflow_o), 128'(1'b1));
    chk("race_flag",      128'(bus.rsp_timeout_o),  128'(1'b0));
    rsp_accept();
`else
    repeat (40) tick();
    chk("wait_unbounded", 128'(bus.rsp_valid_o),   128'(1'b0));
    chk("timeout_tied",   128'(bus.rsp_timeout_o), 128'(1'b0));
    bus.unit_data_valid_i = 1'b1;
    bus.unit_z_i          = 32'h3F800000;
    tick();
    bus.unit_data_valid_i = 1'b0;
    chk("late_unit_rsp_valid", 128'(bus.rsp_valid_o), 128'(1'b1));
    chk("late_unit_rsp_z",     128'(bus.rsp_z_o),     128'(32'h3F800000));
    rsp_accept();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
